// File: rtl/face_search_ctrl_pkg.sv
// Shared types and constants for the face search controller slice.
// Tags carry positions at TAG_POS_W bits; POS_W of the controller must not exceed it.
package face_search_ctrl_pkg;

    localparam int SAD_W        = 32;
    localparam int SAD_PIPE_LAT = 5;
    localparam int TAG_POS_W    = 16;

    localparam logic [SAD_W-1:0] SAD_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_POS_W-1:0] x;
        logic [TAG_POS_W-1:0] y;
    } tag_t;

endpackage

// File: rtl/face_search_ctrl_if.sv
// Handshake, candidate and result bus of face_search_ctrl.
// FACE_SEARCH_EARLY_EXIT_EN adds the sad_thresh input.
interface face_search_ctrl_if #(
    parameter int POS_W = 8
);
    import face_search_ctrl_pkg::*;

    logic             start;
    logic             busy;
    logic             done;
    logic             cand_valid;
    logic             cand_ready;
    logic [POS_W-1:0] cand_x;
    logic [POS_W-1:0] cand_y;
    logic [SAD_W-1:0] sad;
    logic [SAD_W-1:0] best_sad;
    logic [POS_W-1:0] best_x;
    logic [POS_W-1:0] best_y;
`ifdef FACE_SEARCH_EARLY_EXIT_EN
    logic [SAD_W-1:0] sad_thresh;

    modport master (
        output start, cand_ready, sad, sad_thresh,
        input  busy, done, cand_valid, cand_x, cand_y, best_sad, best_x, best_y
    );

    modport slave (
        input  start, cand_ready, sad, sad_thresh,
        output busy, done, cand_valid, cand_x, cand_y, best_sad, best_x, best_y
    );
`else
    modport master (
        output start, cand_ready, sad,
        input  busy, done, cand_valid, cand_x, cand_y, best_sad, best_x, best_y
    );

    modport slave (
        input  start, cand_ready, sad,
        output busy, done, cand_valid, cand_x, cand_y, best_sad, best_x, best_y
    );
`endif

endinterface

// File: rtl/face_search_ctrl_tag_delay.sv
// face_tag_delay: DEPTH-stage tag shift register that re-aligns candidate
// positions with the SAD result; any_valid reports tags still in flight.
module face_tag_delay
    import face_search_ctrl_pkg::*;
#(
    parameter int DEPTH = SAD_PIPE_LAT + 1
) (
    input  logic Bus2IP_Clk,
    input  logic Bus2IP_Reset,
    input  tag_t push_tag,
    output tag_t pop_tag,
    output logic any_valid
);

    tag_t stage_r [DEPTH];

    // Shift unconditionally: the SAD tree downstream never stalls.
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= push_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    // OR of all stage valids.
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage_r[i].valid;
        end
    end

    assign pop_tag = stage_r[DEPTH-1];

endmodule

// File: rtl/face_search_ctrl.sv
// Raster-scan search controller: issues candidate windows, re-aligns returned
// SADs with their positions and reports the minimum. Option: FACE_SEARCH_EARLY_EXIT_EN.
module face_search_ctrl
    import face_search_ctrl_pkg::*;
#(
    parameter int COLS    = 33,
    parameter int ROWS    = 33,
    parameter int POS_W   = 8,
    parameter int SAD_LAT = SAD_PIPE_LAT + 1
) (
    input  logic               Bus2IP_Clk,
    input  logic               Bus2IP_Reset,
    face_search_ctrl_if.slave  bus
);

    state_t           state_r;
    logic             busy_r;
    logic             done_r;
    logic             cand_valid_r;
    logic [POS_W-1:0] cand_x_r;
    logic [POS_W-1:0] cand_y_r;
    logic [SAD_W-1:0] best_sad_r;
    logic [POS_W-1:0] best_x_r;
    logic [POS_W-1:0] best_y_r;
    logic [SAD_W-1:0] min_sad_r;
    logic [POS_W-1:0] min_x_r;
    logic [POS_W-1:0] min_y_r;

    logic accept_s;
    logic cmp_load_s;
    logic early_hit_s;
    logic any_valid_s;
    tag_t push_tag_s;
    tag_t pop_tag_s;

    face_tag_delay #(
        .DEPTH (SAD_LAT)
    ) u_tag_delay (
        .Bus2IP_Clk   (Bus2IP_Clk),
        .Bus2IP_Reset (Bus2IP_Reset),
        .push_tag     (push_tag_s),
        .pop_tag      (pop_tag_s),
        .any_valid    (any_valid_s)
    );

    // Accept decode, delay-line input and strict-less compare (ties keep the raster-first position).
    always_comb begin
        accept_s         = cand_valid_r & bus.cand_ready;
        push_tag_s       = '0;
        push_tag_s.valid = accept_s;
        push_tag_s.x     = TAG_POS_W'(cand_x_r);
        push_tag_s.y     = TAG_POS_W'(cand_y_r);
        cmp_load_s       = pop_tag_s.valid & (bus.sad < min_sad_r);
`ifdef FACE_SEARCH_EARLY_EXIT_EN
        early_hit_s      = cmp_load_s & (bus.sad <= bus.sad_thresh);
`else
        early_hit_s      = 1'b0;
`endif
    end

    // Search FSM with registered handshake, candidate and result outputs.
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            cand_valid_r <= 1'b0;
            cand_x_r     <= '0;
            cand_y_r     <= '0;
            best_sad_r   <= SAD_MAX;
            best_x_r     <= '0;
            best_y_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r      <= ST_SCAN;
                        busy_r       <= 1'b1;
                        cand_valid_r <= 1'b1;
                        cand_x_r     <= '0;
                        cand_y_r     <= '0;
                    end
                end
                ST_SCAN: begin
                    if (early_hit_s) begin
                        state_r      <= ST_DRAIN;
                        cand_valid_r <= 1'b0;
                    end else if (accept_s) begin
                        if (cand_x_r == POS_W'(COLS - 1)) begin
                            cand_x_r <= '0;
                            if (cand_y_r == POS_W'(ROWS - 1)) begin
                                state_r      <= ST_DRAIN;
                                cand_valid_r <= 1'b0;
                            end else begin
                                cand_y_r <= cand_y_r + POS_W'(1'b1);
                            end
                        end else begin
                            cand_x_r <= cand_x_r + POS_W'(1'b1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Running min already holds the last compare once the line is empty.
                    if (!any_valid_s) begin
                        state_r    <= ST_DONE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        best_sad_r <= min_sad_r;
                        best_x_r   <= min_x_r;
                        best_y_r   <= min_y_r;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                    cand_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Running minimum and its position.
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            min_sad_r <= SAD_MAX;
            min_x_r   <= '0;
            min_y_r   <= '0;
        end else if ((state_r == ST_IDLE) && bus.start) begin
            min_sad_r <= SAD_MAX;
            min_x_r   <= '0;
            min_y_r   <= '0;
        end else if (cmp_load_s) begin
            min_sad_r <= bus.sad;
            min_x_r   <= POS_W'(pop_tag_s.x);
            min_y_r   <= POS_W'(pop_tag_s.y);
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.cand_valid = cand_valid_r;
    assign bus.cand_x     = cand_x_r;
    assign bus.cand_y     = cand_y_r;
    assign bus.best_sad   = best_sad_r;
    assign bus.best_x     = best_x_r;
    assign bus.best_y     = best_y_r;

endmodule

// File: tb/tb_face_search_ctrl.sv
// Scoreboard bench for face_search_ctrl on a 3x2 candidate grid.
// Early-exit scenario is built only with FACE_SEARCH_EARLY_EXIT_EN.
module tb_face_search_ctrl;
    import face_search_ctrl_pkg::*;

    localparam int COLS    = 3;
    localparam int ROWS    = 2;
    localparam int POS_W   = 8;
    localparam int SAD_LAT = 6;
    localparam int HIST_N  = 4096;

    typedef struct packed {
        logic [31:0] sad;
        logic [7:0]  x;
        logic [7:0]  y;
    } res_t;

    logic Bus2IP_Clk;
    logic Bus2IP_Reset;

    face_search_ctrl_if #(.POS_W(POS_W)) bus ();

    face_search_ctrl #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .POS_W   (POS_W),
        .SAD_LAT (SAD_LAT)
    ) dut (
        .Bus2IP_Clk   (Bus2IP_Clk),
        .Bus2IP_Reset (Bus2IP_Reset),
        .bus          (bus)
    );

    initial Bus2IP_Clk = 1'b0;
    always #5 Bus2IP_Clk = ~Bus2IP_Clk;

    int   checks;
    int   failures;
    int   cyc;
    res_t exp_q[$];
    res_t prev_best;
    logic hist_v [HIST_N];
    int   hist_x [HIST_N];
    int   hist_y [HIST_N];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge Bus2IP_Clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] sad_of(input int mode, input int x, input int y);
        logic [31:0] v;
        v = 32'(x + 10 * y + 100);
        case (mode)
            0: if (x == 2 && y == 1) v = 32'd7;
            1: if ((x == 1 && y == 0) || (x == 0 && y == 1)) v = 32'd50;
            2: if (x == 1 && y == 0) v = 32'd15;
            default: v = v;
        endcase
        return v;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_busy"},       32'(bus.busy),       32'd0);
        check_val({pfx, "_done"},       32'(bus.done),       32'd0);
        check_val({pfx, "_cand_valid"}, 32'(bus.cand_valid), 32'd0);
        check_val({pfx, "_cand_x"},     32'(bus.cand_x),     32'd0);
        check_val({pfx, "_cand_y"},     32'(bus.cand_y),     32'd0);
        check_val({pfx, "_best_sad"},   bus.best_sad,        32'hFFFF_FFFF);
        check_val({pfx, "_best_x"},     32'(bus.best_x),     32'd0);
        check_val({pfx, "_best_y"},     32'(bus.best_y),     32'd0);
    endtask

    // One full search; rdy_mode 1 toggles cand_ready starting low in the first SCAN cycle.
    task automatic run_search(input int mode, input int rdy_mode, input int exp_lat, input bit poke_start);
        logic [31:0] m;
        int   bx, by, t, ex, ey, dones, done_cyc, acc10, last_acc, a;
        logic rdy, acc;
        res_t r;
        m = 32'hFFFF_FFFF; bx = 0; by = 0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                if (sad_of(mode, x, y) < m) begin
                    m = sad_of(mode, x, y); bx = x; by = y;
                end
            end
        end
        exp_q.push_back({m, 8'(bx), 8'(by)});

        bus.start = 1'b1;
        t = cyc;
        tick();
        bus.start = 1'b0;
        ex = 0; ey = 0; dones = 0; done_cyc = -1; acc10 = -1; last_acc = -1;
        for (int k = 0; k < 200; k++) begin
            if (k == 0) begin
                check_val("cand_valid_after_start", 32'(bus.cand_valid), 32'd1);
                check_val("busy_after_start", 32'(bus.busy), 32'd1);
            end
            if (k == 2) begin
                check_val("best_sad_held", bus.best_sad, prev_best.sad);
            end
            if (bus.done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    r = exp_q.pop_front();
                    check_val("best_sad", bus.best_sad, r.sad);
                    check_val("best_x", 32'(bus.best_x), 32'(r.x));
                    check_val("best_y", 32'(bus.best_y), 32'(r.y));
                    check_val("busy_at_done", 32'(bus.busy), 32'd0);
                    if (exp_lat > 0) begin
                        check_val("done_latency", 32'(cyc - t), 32'(exp_lat));
                    end
                    prev_best = r;
                end
            end
            if (done_cyc >= 0 && cyc - done_cyc == 1) begin
                check_val("idle_after_done", 32'({bus.busy, bus.cand_valid}), 32'd0);
            end
            if (done_cyc >= 0 && cyc - done_cyc >= 4) begin
                break;
            end
            rdy = (rdy_mode == 0) ? 1'b1 : (((cyc - t) % 2) == 0);
            bus.cand_ready = rdy;
            acc = bus.cand_valid & rdy;
            if (acc) begin
                check_val("cand_x", 32'(bus.cand_x), 32'(ex));
                check_val("cand_y", 32'(bus.cand_y), 32'(ey));
                if (ex == 1 && ey == 0) acc10 = cyc;
                last_acc = cyc;
                if (ex == COLS - 1) begin
                    ex = 0; ey++;
                end else begin
                    ex++;
                end
            end
            hist_v[cyc] = acc;
            hist_x[cyc] = int'(bus.cand_x);
            hist_y[cyc] = int'(bus.cand_y);
            a = cyc - SAD_LAT;
            bus.sad = (a >= 0 && hist_v[a]) ? sad_of(mode, hist_x[a], hist_y[a]) : 32'd0;
            bus.start = (poke_start && (cyc - t == 2 || cyc - t == 10 || cyc == done_cyc)) ? 1'b1 : 1'b0;
            tick();
        end
        bus.start = 1'b0;
        if (done_cyc < 0) begin
            check_val("done_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        check_val("done_count", 32'(dones), 32'd1);
        if (mode == 2) begin
            check_val("early_stop", 32'(acc10 >= 0 && last_acc <= acc10 + SAD_LAT), 32'd1);
        end
    endtask

    initial begin
        int dones;
        int t;
        checks = 0; failures = 0; cyc = 0;
        prev_best = {32'hFFFF_FFFF, 8'd0, 8'd0};
        for (int i = 0; i < HIST_N; i++) begin
            hist_v[i] = 1'b0; hist_x[i] = 0; hist_y[i] = 0;
        end
        Bus2IP_Reset = 1'b1;
        bus.start = 1'b0;
        bus.cand_ready = 1'b1;
        bus.sad = 32'd0;
`ifdef FACE_SEARCH_EARLY_EXIT_EN
        bus.sad_thresh = 32'd0;
`endif
        repeat (3) tick();
        check_reset_outputs("por");
        Bus2IP_Reset = 1'b0;
        tick();

        run_search(0, 0, 14, 1'b0);
        run_search(1, 0, 14, 1'b0);
        run_search(0, 1, 20, 1'b0);

        // Abort in the third SCAN cycle.
        bus.cand_ready = 1'b1;
        bus.sad = 32'd0;
        bus.start = 1'b1;
        t = cyc;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check_val("abort_in_scan", 32'(cyc - t), 32'd3);
        Bus2IP_Reset = 1'b1;
        tick();
        check_reset_outputs("abort");
        Bus2IP_Reset = 1'b0;
        prev_best = {32'hFFFF_FFFF, 8'd0, 8'd0};
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.done) dones++;
            tick();
        end
        check_val("abort_no_done", 32'(dones), 32'd0);
        check_val("abort_best_sad", bus.best_sad, 32'hFFFF_FFFF);

        run_search(0, 0, 14, 1'b0);
        run_search(0, 0, 14, 1'b1);

`ifdef FACE_SEARCH_EARLY_EXIT_EN
        bus.sad_thresh = 32'd20;
        run_search(2, 0, -1, 1'b0);
        bus.sad_thresh = 32'd0;
`endif

        check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/face_search_ctrl.md
# face_search_ctrl

Search controller directly downstream of the 32x32 SAD datapath. It scans every candidate window position of the group image in raster order and issues one candidate per accepted cycle to the window loader, which in turn feeds the SAD tree. It re-aligns each returned 32-bit `sad` with its position through a tag delay line and tracks the minimum SAD and where it occurred. The block reports the result with a start/done handshake.

## Interface
- `COLS`, default 33: candidate x positions per row (group width - 31).
- `ROWS`, default 33: candidate y positions.
- `POS_W`, default 8: width of the x/y position fields.
- `SAD_LAT`, default 6: cycles from candidate accept to matching `sad` (1 loader register + 5 SAD pipeline registers).

Ports:
- `Bus2IP_Clk` in 1: single clock, all logic rising-edge.
- `Bus2IP_Reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a search; ignored unless in IDLE.
- `busy` out 1: high in SCAN and DRAIN.
- `done` out 1: one-cycle pulse when the result is valid.
- `cand_valid` out 1: candidate position presented.
- `cand_ready` in 1: window loader accepts the candidate this cycle.
- `cand_x`, `cand_y` out POS_W: candidate window origin.
- `sad` in 32: SAD datapath output, sampled every cycle.
- `best_sad` out 32: minimum SAD of the last completed search.
- `best_x`, `best_y` out POS_W: position of `best_sad`.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: on `start`, go to SCAN. Clear x/y counters to 0. Set running min to 32'hFFFF_FFFF and running position to 0.
- SCAN: `cand_valid`=1. On `cand_valid & cand_ready` (accept), advance x. On x=COLS-1, wrap x to 0 and increment y. Accepting (COLS-1, ROWS-1) moves to DRAIN.
- `cand_ready` low: hold x/y. Insert a bubble (tag valid=0) into the delay line.
- Delay line: SAD_LAT stages of {valid, x, y}. Shifts every cycle unconditionally, because the SAD tree has no stall.
- Compare: when the delay-line output is valid and `sad` < running min (strict), load min/position. Ties keep the earlier, raster-first position.
- DRAIN: wait until the delay line holds no valid tag, then go to DONE.
- DONE: copy running min/position to `best_*`. Pulse `done`. Return to IDLE.
- `start` while busy is ignored. `start` in the DONE cycle is ignored.
- `best_*` hold their values until the next DONE.
- Reset mid-search clears all state, delay-line valids, and outputs. No `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `cand_valid`=0, `cand_x`=`cand_y`=0, `best_sad`=32'hFFFF_FFFF, `best_x`=`best_y`=0.
- `start` at cycle t puts the block in SCAN from t+1, with `cand_valid`=1 at t+1.
- The candidate accepted at cycle a is compared against `sad` at cycle a+SAD_LAT.
- With `cand_ready` held at 1, `done` is asserted at t+1+COLS*ROWS+SAD_LAT+1.
- `busy` drops in the same cycle `done` rises.

## Configuration
- `FACE_SEARCH_EARLY_EXIT_EN` defined:
  - Adds input `sad_thresh` [31:0].
  - When a compare loads a running min ≤ `sad_thresh`, SCAN stops issuing (`cand_valid`=0 next cycle) and goes to DRAIN.
  - Tags already in flight are still compared. A later smaller SAD can still replace the result.
- `FACE_SEARCH_EARLY_EXIT_EN` undefined: no port, and the full scan is always performed.

## Structure
- Shared package holds:
  - the state enum,
  - the tag type {valid, x, y},
  - the SAD width constant 32,
  - the default SAD pipeline latency constant 5.
- One sub-module, `face_tag_delay`: a parameterised SAD_LAT-deep shift register of tags with an `any_valid` output used by DRAIN.

## Test plan
- COLS=3, ROWS=2, `cand_ready`=1, `sad` driven as a function of the returned tag (x+10*y+100, except 7 at (2,1)). Required: `best_sad`=7, `best_x`=2, `best_y`=1, and `done` 14 cycles after `start`.
- Ties: SAD 50 at (1,0) and at (0,1). Required: result (1,0).
- `cand_ready` toggled 1/0 every cycle. Required: same result as the first test, with `done` 6 cycles later.
- Reset asserted in the 3rd SCAN cycle. Required: all outputs at reset values, no `done`. A new `start` then completes normally.
- `start` pulsed while busy. Required: ignored, and one `done` only.
- With `FACE_SEARCH_EARLY_EXIT_EN`, `sad_thresh`=20, SAD 15 at (1,0). Required: no accept after the compare plus one cycle, and `best_sad`=15 at (1,0).
